// File: rtl/spawn_scheduler.sv
// Turns LFSR samples into timed obstacle-spawn events: a tick-driven gap timer,
// a lane/speed picker, and a 4-entry FIFO drained over valid/ready.
//
// state | meaning
// IDLE  | spawning disabled, waiting for enable
// LOAD  | load gap timer with MIN_GAP + rand_in
// WAIT  | count frame ticks down to zero
// PICK  | sample rand_in until a legal, non-repeating lane is found
// SPEED | choose speed 1..3 from rand_in
// PUSH  | write {lane, speed} into the FIFO or count a drop
module spawn_scheduler #(
    parameter int unsigned LANES   = 10,
    parameter int unsigned MIN_GAP = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       tick,
    input  logic [3:0] rand_in,
    input  logic       spawn_ready,
    output logic       spawn_valid,
    output logic [3:0] spawn_lane,
    output logic [1:0] spawn_speed,
    output logic [2:0] pending,
    output logic [7:0] drop_count
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT, PICK, SPEED, PUSH} state_t;

    localparam logic [3:0] LANES_4   = 4'(LANES);
    localparam logic [7:0] MIN_GAP_8 = 8'(MIN_GAP);

    state_t     state, state_nxt;
    logic [7:0] gap_cnt;
    logic [2:0] rej_cnt;
    logic [3:0] last_lane;
    logic [3:0] lane_r;
    logic [1:0] speed_r;
    logic [5:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr, head_idx;
    logic [2:0] count;
    logic       lane_ok, full, pop, push;
    logic [3:0] forced_lane;

    assign lane_ok     = (rand_in < LANES_4) && (rand_in != last_lane);
    assign forced_lane = (last_lane == 4'hF || last_lane + 4'd1 == LANES_4) ? 4'd0
                                                                            : last_lane + 4'd1;
    assign full        = (count == 3'd4);
    assign pop         = spawn_valid & spawn_ready;
    // A full FIFO still takes the write when the head leaves on the same edge.
    assign push        = (state == PUSH) && (!full || pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = LOAD;
            LOAD:    state_nxt = enable ? WAIT : IDLE;
            WAIT: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (tick && gap_cnt == 8'd0) begin
                    state_nxt = PICK;
                end
            end
            PICK:    if (lane_ok || rej_cnt == 3'd7) state_nxt = SPEED;
            SPEED:   state_nxt = PUSH;
            PUSH:    state_nxt = enable ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gap_cnt    <= 8'd0;
            rej_cnt    <= 3'd0;
            last_lane  <= 4'hF;
            lane_r     <= 4'd0;
            speed_r    <= 2'd0;
            drop_count <= 8'd0;
        end else begin
            case (state)
                LOAD: gap_cnt <= MIN_GAP_8 + {4'd0, rand_in};
                WAIT: begin
                    if (enable && tick && gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
                end
                PICK: begin
                    if (lane_ok) begin
                        lane_r  <= rand_in;
                        rej_cnt <= 3'd0;
                    end else if (rej_cnt == 3'd7) begin
                        lane_r  <= forced_lane;
                        rej_cnt <= 3'd0;
                    end else begin
                        rej_cnt <= rej_cnt + 3'd1;
                    end
                end
                SPEED: speed_r <= (rand_in[1:0] == 2'd0) ? 2'd1 : rand_in[1:0];
                PUSH: begin
                    last_lane <= lane_r;
                    if (!push && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) fifo_mem[i] <= 6'd0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {lane_r, speed_r};
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: ;
            endcase
        end
    end

    // When empty, keep presenting the most recently popped slot so outputs hold.
    assign head_idx    = (count == 3'd0) ? rd_ptr - 2'd1 : rd_ptr;
    assign spawn_valid = (count != 3'd0);
    assign spawn_lane  = fifo_mem[head_idx][5:2];
    assign spawn_speed = fifo_mem[head_idx][1:0];
    assign pending     = count;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed bench for spawn_scheduler: expected {lane, speed} entries are queued
// as each scenario is issued and compared by a monitor on every handshake.
module tb_spawn_scheduler;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] rand_in = 4'd0;
    logic       spawn_ready = 1'b0;
    logic       spawn_valid;
    logic [3:0] spawn_lane;
    logic [1:0] spawn_speed;
    logic [2:0] pending;
    logic [7:0] drop_count;

    int checks = 0;
    int failures = 0;
    int n_pops = 0;
    int n_ticks = 0;
    int tick_period = 0;
    int tick_phase = 0;
    int base;
    logic [5:0] sb[$];
    logic [5:0] mon_exp;
    logic [3:0] s2_vec [26];

    spawn_scheduler #(.LANES(10), .MIN_GAP(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .tick        (tick),
        .rand_in     (rand_in),
        .spawn_ready (spawn_ready),
        .spawn_valid (spawn_valid),
        .spawn_lane  (spawn_lane),
        .spawn_speed (spawn_speed),
        .pending     (pending),
        .drop_count  (drop_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        for (int i = 0; i < budget && n_pops < target; i++) @(negedge clock);
        check(name, int'(n_pops >= target), 1);
    endtask

    // Tick generator: period 0 = off, 1 = every cycle, N = one pulse every N cycles.
    always @(posedge clock) begin
        if (tick) n_ticks++;
        #2;
        if (tick_period == 0) begin
            tick = 1'b0;
        end else begin
            tick       = (tick_phase == 0);
            tick_phase = (tick_phase + 1) % tick_period;
        end
    end

    always @(negedge clock) begin
        if (reset && spawn_valid && spawn_ready) begin
            n_pops++;
            check("mon_sb_nonempty", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_exp = sb.pop_front();
                check("mon_head_lane_speed", {spawn_lane, spawn_speed}, mon_exp);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", spawn_valid, 0);
        check("rst_pending", pending, 0);
        check("rst_lane", spawn_lane, 0);
        check("rst_speed", spawn_speed, 0);
        check("rst_drop", drop_count, 0);
        reset = 1'b1;

        // S1: rand 3 held, tick every 4 cycles; lanes alternate 3 and forced 4
        sb.push_back({4'd3, 2'd3});
        sb.push_back({4'd4, 2'd3});
        sb.push_back({4'd3, 2'd3});
        sb.push_back({4'd4, 2'd3});
        step();
        rand_in = 4'd3;
        spawn_ready = 1'b1;
        enable = 1'b1;
        step();
        step();
        n_ticks = 0;
        tick_phase = 0;
        tick_period = 4;
        @(negedge clock);
        for (int i = 0; i < 200 && !spawn_valid; i++) @(negedge clock);
        check("s1_first_gap_ticks", n_ticks, 20);
        wait_pops(4, 600, "s1_four_spawns");
        step();
        enable = 1'b0;
        tick_period = 0;
        repeat (3) step();

        // S2 prelude: one spawn on lane 5 so last_lane = 5
        tick_phase = 0;
        tick_period = 1;
        sb.push_back({4'd5, 2'd1});
        rand_in = 4'd5;
        enable = 1'b1;
        wait_pops(5, 200, "s2_prelude_spawn");
        step();
        enable = 1'b0;
        repeat (3) step();

        // S2: 12,15,11,5 rejected, 7 accepted on the 5th PICK cycle, speed from 2
        for (int i = 0; i < 26; i++) s2_vec[i] = 4'd0;
        s2_vec[19] = 4'd12;
        s2_vec[20] = 4'd15;
        s2_vec[21] = 4'd11;
        s2_vec[22] = 4'd5;
        s2_vec[23] = 4'd7;
        s2_vec[24] = 4'd2;
        sb.push_back({4'd7, 2'd2});
        for (int i = 0; i < 26; i++) begin
            step();
            rand_in = s2_vec[i];
            enable = (i < 25);
        end
        @(negedge clock);
        check("s2_not_before_push", spawn_valid, 0);
        @(negedge clock);
        check("s2_pick5_latency", spawn_valid, 1);
        repeat (3) step();

        // S3: consumer stalled, 6 rounds of rand 0 -> 4 stored, 2 dropped
        sb.push_back({4'd0, 2'd1});
        sb.push_back({4'd1, 2'd1});
        sb.push_back({4'd0, 2'd1});
        sb.push_back({4'd1, 2'd1});
        step();
        spawn_ready = 1'b0;
        rand_in = 4'd0;
        enable = 1'b1;
        for (int i = 0; i < 400 && drop_count != 8'd2; i++) @(negedge clock);
        check("s3_drop_after6", drop_count, 2);
        step();
        enable = 1'b0;
        @(negedge clock);
        check("s3_pending_full", pending, 4);
        repeat (30) step();
        check("s3_pending_holds", pending, 4);
        check("s3_drop_holds", drop_count, 2);

        // S4: full FIFO, ready only in the PUSH cycle -> write accepted, no drop
        sb.push_back({4'd0, 2'd1});
        for (int i = 0; i < 23; i++) begin
            step();
            enable = (i < 21);
            spawn_ready = (i == 21);
        end
        @(negedge clock);
        check("s4_pending_stays4", pending, 4);
        check("s4_drop_unchanged", drop_count, 2);

        step();
        spawn_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock);
            @(negedge clock);
            check("s4_drain_pending", pending, 4 - k);
        end
        check("s4_drain_empty", spawn_valid, 0);

        // S5a: enable dropped in WAIT -> no spawn
        base = n_pops;
        step();
        rand_in = 4'd0;
        enable = 1'b1;
        repeat (10) step();
        enable = 1'b0;
        repeat (60) step();
        check("s5_wait_disable_no_spawn", n_pops, base);
        check("s5_wait_disable_pending", pending, 0);

        // S5b: enable dropped during SPEED -> exactly one more entry
        sb.push_back({4'd6, 2'd2});
        base = n_pops;
        for (int i = 0; i < 27; i++) begin
            step();
            rand_in = 4'd6;
            enable = (i < 26);
        end
        repeat (40) step();
        check("s5_speed_disable_one_spawn", n_pops, base + 1);
        check("s5_speed_disable_pending", pending, 0);

        // S6: reset with 3 pending while in PICK
        step();
        spawn_ready = 1'b0;
        rand_in = 4'd0;
        enable = 1'b1;
        for (int i = 0; i < 400 && pending != 3'd3; i++) @(negedge clock);
        check("s6_three_pending", pending, 3);
        repeat (20) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("s6_rst_valid", spawn_valid, 0);
        check("s6_rst_pending", pending, 0);
        check("s6_rst_drop", drop_count, 0);
        check("s6_rst_lane", spawn_lane, 0);
        sb.delete();
        enable = 1'b0;
        step();
        step();
        reset = 1'b1;
        sb.push_back({4'd0, 2'd1});
        spawn_ready = 1'b1;
        enable = 1'b1;
        base = n_pops;
        wait_pops(base + 1, 200, "s6_post_reset_spawn");
        step();
        enable = 1'b0;
        repeat (3) step();

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
